// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first subtractor computing a - b with one full-subtractor cell and a borrow flop.
// Result, unsigned borrow and signed overflow are registered on entry to DONE and held until the next DONE.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             borrowOut_q, borrowOut_d;
    logic             overflow_q, overflow_d;
    logic [CW-1:0]    count_q, count_d;
    logic             diffBit;
    logic             borrowNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            aShift_q    <= '0;
            bShift_q    <= '0;
            result_q    <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            borrowOut_q <= 1'b0;
            overflow_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            aShift_q    <= aShift_d;
            bShift_q    <= bShift_d;
            result_q    <= result_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            borrowOut_q <= borrowOut_d;
            overflow_q  <= overflow_d;
            count_q     <= count_d;
        end
    end

    // Overflow is the borrow into the MSB cell XOR the borrow out of it.
    always_comb begin
        diffBit     = aShift_q[0] ^ bShift_q[0] ^ borrow_q;
        borrowNext  = (~aShift_q[0] & bShift_q[0]) | (~(aShift_q[0] ^ bShift_q[0]) & borrow_q);
        state_d     = state_q;
        aShift_d    = aShift_q;
        bShift_d    = bShift_q;
        result_d    = result_q;
        diff_d      = diff_q;
        borrow_d    = borrow_q;
        borrowOut_d = borrowOut_q;
        overflow_d  = overflow_q;
        count_d     = count_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    aShift_d = a;
                    bShift_d = b;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                aShift_d = aShift_q >> 1;
                bShift_d = bShift_q >> 1;
                result_d = {diffBit, result_q[WIDTH-1:1]};
                borrow_d = borrowNext;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    diff_d      = {diffBit, result_q[WIDTH-1:1]};
                    borrowOut_d = borrowNext;
                    overflow_d  = borrow_q ^ borrowNext;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrowOut_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus random operands
// compared against an arithmetic reference of a - b, its borrow and signed overflow.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    int checks   = 0;
    int failures = 0;

    int prevDiff = 0;
    int prevBorrow = 0;
    int prevOverflow = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer subtraction and sign comparisons.
    function automatic void refModel(input int av, input int bv,
                                     output int expDiff, output int expBorrow, output int expOverflow);
        int signA, signB, signD;
        expDiff     = (av - bv) & MASK;
        expBorrow   = (av < bv) ? 1 : 0;
        signA       = (av >> (WIDTH - 1)) & 1;
        signB       = (bv >> (WIDTH - 1)) & 1;
        signD       = (expDiff >> (WIDTH - 1)) & 1;
        expOverflow = ((signA != signB) && (signD != signA)) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents operands with a one-cycle start pulse; returns at the negedge after the capture edge.
    task automatic applyStimulus(input int av, input int bv);
        @(negedge clk);
        a     = WIDTH'(av);
        b     = WIDTH'(bv);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runOp(input string tag, input int av, input int bv);
        int eDiff, eBorrow, eOverflow;
        refModel(av, bv, eDiff, eBorrow, eOverflow);
        applyStimulus(av, bv);
        for (int i = 0; i < WIDTH; i++) begin
            checkOutput({tag, "_busy"}, busy, 1);
            checkOutput({tag, "_nodone"}, done, 0);
            checkOutput({tag, "_hold_diff"}, diff, prevDiff);
            checkOutput({tag, "_hold_borrow"}, borrow_out, prevBorrow);
            @(negedge clk);
        end
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_done_busy"}, busy, 0);
        checkOutput({tag, "_diff"}, diff, eDiff);
        checkOutput({tag, "_borrow"}, borrow_out, eBorrow);
        checkOutput({tag, "_overflow"}, overflow, eOverflow);
        prevDiff     = eDiff;
        prevBorrow   = eBorrow;
        prevOverflow = eOverflow;
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, done, 0);
        checkOutput({tag, "_after_diff"}, diff, eDiff);
    endtask

    initial begin
        int eDiff, eBorrow, eOverflow;
        int av, bv;
        logic sawDone;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_diff", diff, 0);
        checkOutput("reset_borrow", borrow_out, 0);
        checkOutput("reset_overflow", overflow, 0);
        reset = 1'b0;
        @(negedge clk);

        runOp("op_5_3", 5, 3);
        runOp("op_3_5", 3, 5);
        runOp("op_7_8", 7, 8);
        runOp("op_8_1", 8, 1);
        runOp("op_3_5b", 3, 5);
        runOp("op_0_0", 0, 0);
        runOp("op_15_15", 15, 15);
        runOp("op_0_15", 0, 15);

        // Second start during SHIFT with new operands must be ignored.
        refModel(6, 2, eDiff, eBorrow, eOverflow);
        applyStimulus(6, 2);
        @(negedge clk);
        a     = 4'd1;
        b     = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("ignore_busy", busy, 1);
        @(negedge clk);
        checkOutput("ignore_done", done, 1);
        checkOutput("ignore_diff", diff, eDiff);
        checkOutput("ignore_borrow", borrow_out, eBorrow);
        checkOutput("ignore_overflow", overflow, eOverflow);
        @(negedge clk);
        checkOutput("ignore_single_pulse", done, 0);
        @(negedge clk);
        checkOutput("ignore_no_restart", busy, 0);
        prevDiff = eDiff; prevBorrow = eBorrow; prevOverflow = eOverflow;

        // Start held high: the next operation uses operands present at the IDLE edge after DONE.
        @(negedge clk);
        a     = 4'd2;
        b     = 4'd1;
        start = 1'b1;
        for (int i = 0; i < 3 * WIDTH && !done; i++) @(negedge clk);
        refModel(2, 1, eDiff, eBorrow, eOverflow);
        checkOutput("cont_done1", done, 1);
        checkOutput("cont_diff1", diff, eDiff);
        a = 4'd10;
        b = 4'd3;
        @(negedge clk);
        checkOutput("cont_gap", done, 0);
        for (int i = 0; i < 3 * WIDTH && !done; i++) @(negedge clk);
        refModel(10, 3, eDiff, eBorrow, eOverflow);
        checkOutput("cont_done2", done, 1);
        checkOutput("cont_diff2", diff, eDiff);
        checkOutput("cont_borrow2", borrow_out, eBorrow);
        checkOutput("cont_overflow2", overflow, eOverflow);
        start = 1'b0;
        prevDiff = eDiff; prevBorrow = eBorrow; prevOverflow = eOverflow;
        @(negedge clk);
        @(negedge clk);

        // Reset two cycles into SHIFT aborts with no done pulse.
        applyStimulus(3, 5);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_diff", diff, 0);
        checkOutput("abort_borrow", borrow_out, 0);
        checkOutput("abort_overflow", overflow, 0);
        @(negedge clk);
        reset   = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            sawDone = sawDone | done;
        end
        checkOutput("abort_no_done", sawDone, 0);
        prevDiff = 0; prevBorrow = 0; prevOverflow = 0;
        runOp("op_9_4", 9, 4);

        for (int i = 0; i < 16; i++) begin
            av = int'($urandom_range(0, MASK));
            bv = int'($urandom_range(0, MASK));
            runOp("rand", av, bv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
